// File: rtl/mdu_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mdu_wb_fifo (with package mdu_wb_fifo_pkg)
// Purpose  : In-order write-back buffer between the MDU and the CDB arbiter.
//            Holds up to DEPTH completed multiply/divide results and presents
//            the oldest one to the arbiter. in_ready_o feeds the MDU's
//            fifo_ready, so the MDU stalls exactly when this buffer is full.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            flush           - pipeline flush, same effect as rst
//            in_valid_i/in_data_i/in_ready_o    - MDU result handshake
//            out_valid_o/out_data_o/out_ready_i - head entry toward CDB
//            count_o         - occupancy 0..DEPTH
//            afull_o         - count_o >= AFULL_TH
// Options  : MDU_WB_FIFO_BYPASS_EN - zero-latency bypass when empty
// Revision : 1.0 - initial release
// ============================================================================

package mdu_wb_fifo_pkg;
  typedef struct packed {
    logic [31:0] w_data;
    logic [5:0]  rob_id;
    logic [4:0]  w_reg;
    logic        r_valid;
    logic [7:0]  lsu_info;
    logic [3:0]  ctrl;
  } cdb_info_t;
endpackage

module mdu_wb_fifo
  import mdu_wb_fifo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PTR_LEN  = $clog2(DEPTH),
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid_i,
  input  cdb_info_t          in_data_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  output cdb_info_t          out_data_o,
  input  logic               out_ready_i,
  output logic [PTR_LEN:0]   count_o,
  output logic               afull_o
);

  localparam logic [PTR_LEN:0]   C_FULL_CNT = (PTR_LEN+1)'(DEPTH);
  localparam logic [PTR_LEN:0]   C_AFULL_TH = (PTR_LEN+1)'(AFULL_TH);
  localparam logic [PTR_LEN-1:0] C_PTR_ONE  = PTR_LEN'(1);

  cdb_info_t          mem_q [DEPTH];
  logic [PTR_LEN-1:0] head_q, head_d;
  logic [PTR_LEN-1:0] tail_q, tail_d;
  logic [PTR_LEN:0]   cnt_q,  cnt_d;

  logic push, pop;
  logic wr_en, rd_en;   // storage-level write/read after bypass consumption
  logic clear;

  assign clear      = rst | flush;
  assign in_ready_o = (cnt_q != C_FULL_CNT);
  assign count_o    = cnt_q;
  assign afull_o    = (cnt_q >= C_AFULL_TH);

`ifdef MDU_WB_FIFO_BYPASS_EN
  logic bypass_take;

  // When empty, the incoming result is shown directly on the output. If the
  // arbiter takes it in the same cycle it never touches the storage.
  assign out_valid_o = (cnt_q != '0) | in_valid_i;
  assign out_data_o  = (cnt_q == '0) ? in_data_i : mem_q[head_q];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign bypass_take = (cnt_q == '0) & in_valid_i & out_ready_i;
  assign wr_en       = push & ~bypass_take;
  assign rd_en       = pop & ~bypass_take;
`else
  // Outputs come only from registered state: no in->out combinational path.
  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = mem_q[head_q];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign wr_en       = push;
  assign rd_en       = pop;
`endif

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clear) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_en) tail_d = tail_q + C_PTR_ONE;
      if (rd_en) head_d = head_q + C_PTR_ONE;
      unique case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; a push in a clear cycle is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem_q[tail_q] <= in_data_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_wb_fifo
// Purpose  : Self-checking bench for mdu_wb_fifo (table of per-cycle vectors
//            plus a hand-written bypass/latency sequence).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_wb_fifo;
  import mdu_wb_fifo_pkg::*;

`ifdef MDU_WB_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  cdb_info_t  in_data = '0;
  logic       in_ready;
  logic       out_valid;
  cdb_info_t  out_data;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  logic       afull;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mdu_wb_fifo #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready),
    .count_o    (count),
    .afull_o    (afull)
  );

  typedef struct {
    logic       rst, flush, iv;
    logic [5:0] rob;
    logic       ordy;
    logic       chk;
    logic       ov;
    logic [5:0] erob;
    logic [2:0] cnt;
    logic       af, irdy;
  } vec_t;

  vec_t tbl[$];

  // Every field derived from rob_id so a whole-record compare catches
  // corruption in any field; r_valid alternates to exercise r_valid = 0.
  function automatic cdb_info_t make_data(input logic [5:0] r);
    cdb_info_t d;
    d.w_data   = 32'h0000_122F + {26'b0, r};
    d.rob_id   = r;
    d.w_reg    = r[4:0] ^ 5'h1F;
    d.r_valid  = r[0];
    d.lsu_info = {2'b0, r};
    d.ctrl     = r[3:0];
    return d;
  endfunction

  function automatic vec_t mk(input logic r, f, iv, input logic [5:0] rob,
                              input logic ordy, chk, ov, input logic [5:0] erob,
                              input logic [2:0] cnt, input logic af, irdy);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.rob = rob; v.ordy = ordy;
    v.chk = chk; v.ov = ov; v.erob = erob; v.cnt = cnt; v.af = af; v.irdy = irdy;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, f, iv, input logic [5:0] rob, input logic ordy);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_data = make_data(rob); out_ready = ordy;
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic       e_ov;
    logic [5:0] e_rob;
    drive(v.rst, v.flush, v.iv, v.rob, v.ordy);
    if (v.chk) begin
      e_ov  = v.ov;
      e_rob = v.erob;
      // With bypass an empty buffer shows the incoming result immediately.
      if (BYP && v.cnt == 3'd0 && v.iv && !v.rst && !v.flush) begin
        e_ov  = 1'b1;
        e_rob = v.rob;
      end
      cmp($sformatf("v%0d_out_valid", idx), {63'b0, out_valid}, {63'b0, e_ov});
      cmp($sformatf("v%0d_count", idx), {61'b0, count}, {61'b0, v.cnt});
      cmp($sformatf("v%0d_afull", idx), {63'b0, afull}, {63'b0, v.af});
      cmp($sformatf("v%0d_in_ready", idx), {63'b0, in_ready}, {63'b0, v.irdy});
      if (e_ov)
        cmp($sformatf("v%0d_out_data", idx), {8'b0, out_data}, {8'b0, make_data(e_rob)});
    end
  endtask

  initial begin
    //                rst f iv rob ordy chk ov erob cnt af irdy
    // Reset then idle
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    // Single push then pop
    tbl.push_back(mk(0, 0, 1, 5, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 5, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 5, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    // Fill 1..4, hold 5th, pop, accept 5th, drain
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 2, 0, 1, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 3, 0, 1, 1, 1, 2, 0, 1));
    tbl.push_back(mk(0, 0, 1, 4, 0, 1, 1, 1, 3, 1, 1));
    tbl.push_back(mk(0, 0, 1, 5, 0, 1, 1, 1, 4, 1, 0));
    tbl.push_back(mk(0, 0, 1, 5, 1, 1, 1, 1, 4, 1, 0));
    tbl.push_back(mk(0, 0, 1, 5, 0, 1, 1, 2, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 2, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 3, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 4, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 5, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    // Preload two (40, 41), then 20 cycles of concurrent push/pop
    tbl.push_back(mk(0, 0, 1, 40, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 41, 0, 1, 1, 40, 1, 0, 1));
    for (int i = 0; i < 20; i++) begin
      logic [5:0] r, e;
      r = 6'(i);
      e = (i < 2) ? 6'(40 + i) : 6'(i - 2);
      tbl.push_back(mk(0, 0, 1, r, 1, 1, 1, e, 2, 0, 1));
    end
    // Queue now holds 18,19. Push 20, then flush with push of 9.
    tbl.push_back(mk(0, 0, 1, 20, 0, 1, 1, 18, 2, 0, 1));
    tbl.push_back(mk(0, 1, 1, 9, 0, 1, 1, 18, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    // After flush the next result out must be 10, never 9
    tbl.push_back(mk(0, 0, 1, 10, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 10, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Empty buffer, result 7 offered with arbiter ready.
    drive(0, 0, 1, 7, 1);
`ifdef MDU_WB_FIFO_BYPASS_EN
    cmp("byp_same_cycle_valid", {63'b0, out_valid}, 64'd1);
    cmp("byp_same_cycle_data", {8'b0, out_data}, {8'b0, make_data(6'd7)});
    drive(0, 0, 0, 0, 0);
    cmp("byp_count_after", {61'b0, count}, 64'd0);
    cmp("byp_valid_after", {63'b0, out_valid}, 64'd0);
`else
    cmp("lat_same_cycle_valid", {63'b0, out_valid}, 64'd0);
    drive(0, 0, 0, 0, 1);
    cmp("lat_next_valid", {63'b0, out_valid}, 64'd1);
    cmp("lat_next_data", {8'b0, out_data}, {8'b0, make_data(6'd7)});
    cmp("lat_next_count", {61'b0, count}, 64'd1);
    drive(0, 0, 0, 0, 0);
    cmp("lat_drained_count", {61'b0, count}, 64'd0);
    cmp("lat_drained_valid", {63'b0, out_valid}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
